// File: rtl/text_scan_controller.sv
// text_scan_controller: text-mode raster sequencer issuing screen-RAM reads one cell ahead
// and driving character-generator controls plus VGA syncs.
module text_scan_controller #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int ADDR_W = 12
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [3:0]        ram_rdata,
  output logic [3:0]        character,
  output logic [2:0]        dot_count,
  output logic [3:0]        scan_count,
  output logic              gen_en,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              frame_start
);
  localparam int H_ACT = COLS * 8;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_ACT = ROWS * 16;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam logic [HW-1:0] HA_END  = HW'(H_ACT - 1);
  localparam logic [HW-1:0] HF_END  = HW'(H_ACT + H_FP - 1);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_END   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_PRE   = HW'(H_TOT - 3);
  localparam logic [HW-1:0] H_RDLIM = HW'(H_ACT - 8);
  localparam logic [VW-1:0] VA_END  = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VF_END  = VW'(V_ACT + V_FP - 1);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_END   = VW'(V_TOT - 1);
  localparam logic [ADDR_W-1:0] A_COLS = ADDR_W'(COLS);

  typedef enum logic [1:0] {S_ACT, S_FP, S_SYNC, S_BP} phase_t;

  phase_t            r_hstate, r_vstate, w_hs_n, w_vs_n;
  logic [HW-1:0]     r_hcnt;
  logic [VW-1:0]     r_vcnt;
  logic [ADDR_W-1:0] r_row_base, w_addr;
  logic              r_rd, r_rdv, w_hend, w_vend, w_cell_rd, w_pre_rd;

  assign w_hend = r_hcnt == H_END;
  assign w_vend = r_vcnt == V_END;
  assign w_hs_n = r_hcnt == HA_END ? S_FP : r_hcnt == HF_END ? S_SYNC :
                  r_hcnt == HS_END ? S_BP : w_hend ? S_ACT : r_hstate;
  assign w_vs_n = r_vcnt == VA_END ? S_FP : r_vcnt == VF_END ? S_SYNC :
                  r_vcnt == VS_END ? S_BP : w_vend ? S_ACT : r_vstate;
  // Read strobes are registered, so they are decoded one pixel early.
  assign w_cell_rd = r_vstate == S_ACT && r_hcnt[2:0] == 3'd5 && r_hcnt < H_RDLIM;
  assign w_pre_rd  = r_hcnt == H_PRE && (r_vcnt < VA_END || w_vend);
  assign w_addr = w_cell_rd ? r_row_base + ADDR_W'(r_hcnt[HW-1:3]) + ADDR_W'(1) :
                  w_vend ? '0 : r_vcnt[3:0] == 4'hf ? r_row_base + A_COLS : r_row_base;

  assign ram_rd      = r_rd & en;
  assign dot_count   = r_hcnt[2:0];
  assign scan_count  = r_vcnt[3:0];
  assign gen_en      = rst_n & en & (r_hstate == S_ACT) & (r_vstate == S_ACT);
  assign frame_start = rst_n & en & (r_hcnt == '0) & (r_vcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_hstate   <= S_ACT;
      r_vstate   <= S_ACT;
      r_row_base <= '0;
      r_rd       <= 1'b0;
      r_rdv      <= 1'b0;
      ram_addr   <= '0;
      character  <= '0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
    end else if (en) begin
      r_hcnt   <= w_hend ? '0 : r_hcnt + 1'b1;
      r_hstate <= w_hs_n;
      hsync_n  <= w_hs_n != S_SYNC;
      r_rd     <= w_cell_rd | w_pre_rd;
      r_rdv    <= r_rd;
      if (w_cell_rd | w_pre_rd) ram_addr <= w_addr;
      if (r_rdv) character <= ram_rdata;
      if (w_hend) begin
        r_vcnt     <= w_vend ? '0 : r_vcnt + 1'b1;
        r_vstate   <= w_vs_n;
        vsync_n    <= w_vs_n != S_SYNC;
        r_row_base <= w_vend ? '0 : (r_vstate == S_ACT && r_vcnt[3:0] == 4'hf) ? r_row_base + A_COLS : r_row_base;
      end
    end
  end
endmodule

// File: tb/tb_text_scan_controller.sv
// tb_text_scan_controller: directed checks plus per-pixel reference model for text_scan_controller
// (short vertical timing: 2 text rows, 3/2/3 line porches/sync, so a frame is 40 lines).
module tb_text_scan_controller;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        ram_rd;
  logic [11:0] ram_addr;
  logic [3:0]  ram_rdata;
  logic [3:0]  character;
  logic [2:0]  dot_count;
  logic [3:0]  scan_count;
  logic        gen_en, hsync_n, vsync_n, frame_start;
  int          n_tot = 0, n_bad = 0;
  int          m_h, m_v;
  logic        scan_on = 1'b0;

  text_scan_controller #(.COLS(80), .ROWS(2), .V_FP(3), .V_SYNC(2), .V_BP(3), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .character(character), .dot_count(dot_count), .scan_count(scan_count), .gen_en(gen_en),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd) ram_rdata <= ram_addr[3:0];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_h <= 0;
      m_v <= 0;
    end else if (en) begin
      m_h <= m_h == 799 ? 0 : m_h + 1;
      if (m_h == 799) m_v <= m_v == 39 ? 0 : m_v + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s h=%0d v=%0d got=%h exp=%h", tag, m_h, m_v, got, exp);
    end
  endtask

  task automatic go_to(input int h, input int v);
    int i;
    for (i = 0; i < 50000 && !(m_h == h && m_v == v); i++) @(negedge clk);
    if (i == 50000) chk("timeout", 32'(m_h), 32'(h));
  endtask

  always @(negedge clk) begin
    logic e_rd, e_gen;
    int   e_addr, e_chr;
    if (rst_n && scan_on && n_bad < 40) begin
      e_rd   = en && ((m_h % 8 == 6 && m_h < 632 && m_v < 32) || (m_h == 798 && (m_v < 31 || m_v == 39)));
      e_addr = !e_rd ? 0 : m_h == 798 ? (m_v == 39 ? 0 : ((m_v + 1) / 16) * 80) : (m_v / 16) * 80 + m_h / 8 + 1;
      e_gen  = en && m_h < 640 && m_v < 32;
      e_chr  = e_gen ? ((m_v / 16) * 80 + m_h / 8) % 16 : 0;
      chk("cyc", {ram_rd, e_rd ? ram_addr : 12'd0, e_gen ? character : 4'd0, dot_count, scan_count,
                  gen_en, hsync_n, vsync_n, frame_start},
                 {e_rd, 12'(e_addr), 4'(e_chr), 3'(m_h % 8), 4'(m_v % 16), e_gen,
                  !(m_h >= 656 && m_h <= 751), !(m_v == 35 || m_v == 36), en && m_h == 0 && m_v == 0});
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gen", gen_en, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_syn", {hsync_n, vsync_n}, 2'b11);
    chk("rst_chr", character, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("c0_fs", frame_start, 1);
    chk("c0_gen", gen_en, 1);
    chk("c0_dot", dot_count, 0);
    chk("c0_syn", {hsync_n, vsync_n}, 2'b11);
    scan_on = 1'b1;
    go_to(6, 0);   chk("a1", {ram_rd, ram_addr}, {1'b1, 12'd1});
    go_to(14, 0);  chk("a2", {ram_rd, ram_addr}, {1'b1, 12'd2});
    go_to(15, 0);  chk("ch1", character, 1);
    go_to(16, 0);  chk("ch2", character, 2);
    go_to(630, 0); chk("a79", {ram_rd, ram_addr}, {1'b1, 12'd79});
    go_to(638, 0); chk("no_rd", ram_rd, 0);
    go_to(655, 0); chk("hs655", hsync_n, 1);
    go_to(656, 0); chk("hs656", hsync_n, 0);
    go_to(751, 0); chk("hs751", hsync_n, 0);
    go_to(752, 0); chk("hs752", hsync_n, 1);
    go_to(798, 0); chk("pre0", {ram_rd, ram_addr}, {1'b1, 12'd0});
    go_to(0, 1);   chk("l1ch", character, 0);
    go_to(300, 1);
    #2 en = 1'b0;
    repeat (37) begin
      @(negedge clk);
      chk("frz", {dot_count, scan_count, ram_rd, gen_en, frame_start}, {3'd4, 4'd1, 3'b000});
    end
    #2 en = 1'b1;
    go_to(301, 1);  chk("resume", dot_count, 5);
    go_to(798, 15); chk("pre80", {ram_rd, ram_addr}, {1'b1, 12'd80});
    go_to(0, 16);   chk("sc_wrap", {scan_count, character}, {4'd0, 4'd0});
    go_to(8, 16);   chk("r1ch", character, 1);
    go_to(798, 31); chk("no_pre31", ram_rd, 0);
    go_to(0, 32);   chk("vb_gen", gen_en, 0);
    go_to(6, 32);   chk("vb_rd", ram_rd, 0);
    go_to(0, 34);   chk("vs34", vsync_n, 1);
    go_to(0, 35);   chk("vs35", vsync_n, 0);
    go_to(799, 36); chk("vs36", vsync_n, 0);
    go_to(0, 37);   chk("vs37", vsync_n, 1);
    go_to(798, 39); chk("pre_f", {ram_rd, ram_addr}, {1'b1, 12'd0});
    go_to(0, 0);    chk("f1_fs", {frame_start, character}, {1'b1, 4'd0});
    go_to(400, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gen", gen_en, 0);
    chk("ar_cnt", {dot_count, scan_count}, 0);
    chk("ar_rd", {ram_rd, ram_addr, character}, 0);
    chk("ar_syn", {hsync_n, vsync_n, frame_start}, 3'b110);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rr_fs", {frame_start, dot_count, scan_count}, {1'b1, 7'd0});
    go_to(6, 0);    chk("rr_a1", {ram_rd, ram_addr}, {1'b1, 12'd1});
    scan_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
